// File: rtl/i2s_rec_if.sv
// Wishbone write port used by the I2S recorder to reach the shared SRAM.
// The recorder is the master; the SRAM arbiter is the slave.
interface i2s_rec_if #(
    parameter int ADDR_W = 19
);
    logic              wb_cyc_o;
    logic              wb_we_o;
    logic [ADDR_W-1:0] wb_adr_o;
    logic [7:0]        wb_dat_o;
    logic              wb_ack_i;

    modport master (
        output wb_cyc_o,
        output wb_we_o,
        output wb_adr_o,
        output wb_dat_o,
        input  wb_ack_i
    );

    modport slave (
        input  wb_cyc_o,
        input  wb_we_o,
        input  wb_adr_o,
        input  wb_dat_o,
        output wb_ack_i
    );
endinterface

// File: rtl/i2s_rec.sv
// I2S slave receiver that records stereo frames into SRAM as four
// little-endian bytes (L lo, L hi, R lo, R hi) over a Wishbone write port.
module i2s_rec #(
    parameter int SAMPLE_W   = 16,
    parameter int ADDR_W     = 19,
    parameter int START_ADDR = 44
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic              bclk_i,
    input  logic              wclk_i,
    input  logic              din_i,
    input  logic [ADDR_W-1:0] end_addr_i,
    i2s_rec_if.master         wb,
    output logic [ADDR_W-1:0] addr_o,
    output logic              busy_o,
    output logic              full_o,
    output logic              overrun_o
);
    localparam int                CNT_W   = $clog2(SAMPLE_W + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SAMPLE_W);
    localparam logic [ADDR_W-1:0] START_A = ADDR_W'(START_ADDR);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_GAP
    } state_t;

    // ---------------- input synchronizers ----------------
    logic [2:0] w_async_in;
    logic [2:0] w_sync;
    assign w_async_in = {din_i, wclk_i, bclk_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_sync
            logic r_s1;
            logic r_s2;
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    r_s1 <= 1'b0;
                    r_s2 <= 1'b0;
                end else begin
                    r_s1 <= w_async_in[gi];
                    r_s2 <= r_s1;
                end
            end
            assign w_sync[gi] = r_s2;
        end
    endgenerate

    logic r_bclk_d;
    logic w_bedge;
    logic w_ws;
    logic w_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_bclk_d <= 1'b0;
        else       r_bclk_d <= w_sync[0];
    end

    assign w_bedge = w_sync[0] & ~r_bclk_d;
    assign w_ws    = w_sync[1];
    assign w_d     = w_sync[2];

    // ---------------- deserializer ----------------
    logic [SAMPLE_W-1:0] r_shift;
    logic [SAMPLE_W-1:0] r_left;
    logic [SAMPLE_W-1:0] r_right;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_ws_d;
    logic                r_word_ok;
    logic                r_left_ok;
    logic                r_frame_rdy;
    logic                r_armed;
    logic [SAMPLE_W-1:0] w_shift_in;

    // Bits past SAMPLE_W are dropped; the change edge still carries the LSB of
    // a word that is exactly SAMPLE_W long.
    assign w_shift_in = (r_cnt < CNT_MAX) ? {r_shift[SAMPLE_W-2:0], w_d} : r_shift;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_shift     <= '0;
            r_left      <= '0;
            r_right     <= '0;
            r_cnt       <= '0;
            r_ws_d      <= 1'b0;
            r_word_ok   <= 1'b0;
            r_left_ok   <= 1'b0;
            r_frame_rdy <= 1'b0;
        end else begin
            r_frame_rdy <= 1'b0;
            if (!r_armed) begin
                r_word_ok <= 1'b0;
                r_left_ok <= 1'b0;
            end
            if (w_bedge) begin
                r_ws_d <= w_ws;
                if (w_ws != r_ws_d) begin
                    r_shift   <= w_shift_in;
                    r_cnt     <= '0;
                    r_word_ok <= r_armed;
                    if (r_ws_d) begin
                        r_right   <= w_shift_in;
                        r_left_ok <= 1'b0;
                        if (r_word_ok && r_armed && r_left_ok)
                            r_frame_rdy <= 1'b1;
                    end else begin
                        r_left    <= w_shift_in;
                        r_left_ok <= r_word_ok && r_armed;
                    end
                end else if (r_cnt < CNT_MAX) begin
                    r_shift <= w_shift_in;
                    r_cnt   <= r_cnt + 1'b1;
                end
            end
        end
    end

    // ---------------- write FSM and control ----------------
    state_t            r_state, w_state_next;
    logic [1:0]        r_idx, w_idx_next;
    logic [ADDR_W-1:0] r_addr, w_addr_next;
    logic [31:0]       r_hold, w_hold_next;
    logic              r_full, w_full_next;
    logic              r_overrun, w_overrun_next;
    logic              w_armed_next;
    logic              r_en_d;
    logic              w_fits;
    logic [7:0]        w_byte;
    logic [15:0]       w_l16;
    logic [15:0]       w_r16;

    assign w_l16  = 16'(r_left);
    assign w_r16  = 16'(r_right);
    // Widened by one bit so a frame near the top of memory cannot wrap past the check.
    assign w_fits = ({1'b0, r_addr} + (ADDR_W+1)'(3)) <= {1'b0, end_addr_i};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            r_idx     <= 2'd0;
            r_addr    <= START_A;
            r_hold    <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
            r_armed   <= 1'b0;
            r_en_d    <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_addr    <= w_addr_next;
            r_hold    <= w_hold_next;
            r_full    <= w_full_next;
            r_overrun <= w_overrun_next;
            r_armed   <= w_armed_next;
            r_en_d    <= enable_i;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_idx_next     = r_idx;
        w_addr_next    = r_addr;
        w_hold_next    = r_hold;
        w_full_next    = r_full;
        w_overrun_next = r_overrun;
        w_armed_next   = r_armed;

        case (r_state)
            ST_IDLE: begin
                if (r_frame_rdy) begin
                    if (w_fits) begin
                        w_state_next = ST_REQ;
                        w_idx_next   = 2'd0;
                        w_hold_next  = {w_r16, w_l16};
                    end else begin
                        w_full_next  = 1'b1;
                        w_armed_next = 1'b0;
                    end
                end
            end
            ST_REQ: begin
                if (wb.wb_ack_i) w_state_next = ST_GAP;
            end
            ST_GAP: begin
                w_addr_next = r_addr + 1'b1;
                if (r_idx == 2'd3) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_idx_next   = r_idx + 2'd1;
                    w_state_next = ST_REQ;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase

        // A write in flight is never abandoned; the newer frame is the one lost.
        if (r_frame_rdy && (r_state != ST_IDLE)) w_overrun_next = 1'b1;

        if (!enable_i && r_en_d) w_armed_next = 1'b0;

        if (enable_i && !r_en_d) begin
            w_armed_next   = 1'b1;
            w_addr_next    = START_A;
            w_full_next    = 1'b0;
            w_overrun_next = 1'b0;
        end
    end

    always_comb begin
        case (r_idx)
            2'd0:    w_byte = r_hold[7:0];
            2'd1:    w_byte = r_hold[15:8];
            2'd2:    w_byte = r_hold[23:16];
            default: w_byte = r_hold[31:24];
        endcase
    end

    assign wb.wb_cyc_o = (r_state == ST_REQ);
    assign wb.wb_we_o  = (r_state == ST_REQ);
    assign wb.wb_adr_o = (r_state == ST_REQ) ? r_addr : '0;
    assign wb.wb_dat_o = (r_state == ST_REQ) ? w_byte : 8'd0;

    assign addr_o    = r_addr;
    assign busy_o    = r_armed | (r_state != ST_IDLE);
    assign full_o    = r_full;
    assign overrun_o = r_overrun;
endmodule

// File: tb/tb_i2s_rec.sv
// Bench for the I2S recorder: drives I2S frames with random sample data and
// compares the SRAM byte writes against a frame-level recording model.
module tb_i2s_rec;
    localparam int AW = 19;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic          bclk = 1'b0;
    logic          wclk = 1'b0;
    logic          din = 1'b0;
    logic [AW-1:0] end_addr = '1;
    logic [AW-1:0] addr_o;
    logic          busy;
    logic          full;
    logic          ovr;

    bit            ack_en = 1'b1;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [31:0]   got[$];
    logic [31:0]   exp_q[$];
    logic [15:0]   tx_l[$];
    logic [15:0]   tx_r[$];
    int            exp_addr;
    bit            exp_full;

    i2s_rec_if #(.ADDR_W(AW)) wbif ();

    i2s_rec #(.SAMPLE_W(16), .ADDR_W(AW), .START_ADDR(44)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .enable_i   (enable),
        .bclk_i     (bclk),
        .wclk_i     (wclk),
        .din_i      (din),
        .end_addr_i (end_addr),
        .wb         (wbif),
        .addr_o     (addr_o),
        .busy_o     (busy),
        .full_o     (full),
        .overrun_o  (ovr)
    );

    always #5 clk = ~clk;

    // SRAM responder: one-cycle ack per byte, logging each accepted write.
    always @(negedge clk) begin
        if (wbif.wb_cyc_o && ack_en) begin
            if (wbif.wb_ack_i !== 1'b1) begin
                got.push_back({5'd0, wbif.wb_adr_o, wbif.wb_dat_o});
                $display("write adr=%0d dat=%02h we=%0b", wbif.wb_adr_o, wbif.wb_dat_o, wbif.wb_we_o);
            end
            wbif.wb_ack_i = 1'b1;
        end else begin
            wbif.wb_ack_i = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; bclk = 1'b0; wclk = 1'b0; din = 1'b0; ack_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        got.delete();
        tx_l.delete();
        tx_r.delete();
    endtask

    task automatic send_bit(input bit ws, input bit d);
        bclk = 1'b0; wclk = ws; din = d;
        repeat (3) @(negedge clk);
        bclk = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Standard I2S: the MSB follows the ws change by one bit, so the change
    // bit carries the previous word's LSB only when a slot is 16 bits long.
    task automatic send_stream(input int nb);
        logic [15:0] w[$];
        bit          wsq[$];
        logic [15:0] cur;
        logic [15:0] prev;
        bit          b;
        w.push_back(16'($urandom)); wsq.push_back(1'b1);
        for (int f = 0; f < tx_l.size(); f++) begin
            w.push_back(tx_l[f]); wsq.push_back(1'b0);
            w.push_back(tx_r[f]); wsq.push_back(1'b1);
        end
        w.push_back(16'($urandom)); wsq.push_back(1'b0);
        for (int s = 0; s < w.size(); s++) begin
            cur  = w[s];
            prev = (s > 0) ? w[s-1] : 16'd0;
            for (int j = 0; j < nb; j++) begin
                if (j == 0) b = (s > 0 && nb == 16) ? prev[0] : 1'b0;
                else        b = (j <= 16) ? cur[16-j] : 1'b0;
                send_bit(wsq[s], b);
            end
        end
        bclk = 1'b0;
        repeat (30) @(negedge clk);
    endtask

    // Frame-level model: each recorded frame takes 4 bytes from 44 upward until
    // the next frame would pass end_a; skip marks a frame lost to overrun.
    task automatic model_run(input int nfr, input int end_a, input int skip);
        int          a;
        logic [15:0] lf;
        logic [15:0] rf;
        a = 44; exp_full = 1'b0; exp_q.delete();
        for (int f = 0; f < nfr; f++) begin
            if (f == skip || exp_full) continue;
            if (a + 3 <= end_a) begin
                lf = tx_l[f]; rf = tx_r[f];
                exp_q.push_back({5'd0, 19'(a),     lf[7:0]});
                exp_q.push_back({5'd0, 19'(a + 1), lf[15:8]});
                exp_q.push_back({5'd0, 19'(a + 2), rf[7:0]});
                exp_q.push_back({5'd0, 19'(a + 3), rf[15:8]});
                a += 4;
            end else begin
                exp_full = 1'b1;
            end
        end
        exp_addr = a;
    endtask

    task automatic test_reset();
        int  t;
        bit  seen;
        do_reset();
        ack_en = 1'b0;
        end_addr = '1;
        enable = 1'b1;
        tx_l.push_back(16'($urandom)); tx_r.push_back(16'($urandom));
        fork
            send_stream(32);
            begin
                seen = 1'b0;
                for (t = 0; t < 3000 && !seen; t++) begin
                    @(negedge clk);
                    if (wbif.wb_cyc_o === 1'b1) seen = 1'b1;
                end
                n_cmp++;
                if (!seen) begin
                    n_err++; $display("FAIL reset_cyc_seen: got cyc never high, want cyc high within 3000 cycles");
                end
                #2 rst = 1'b1;
                #1;
                n_cmp++;
                if (wbif.wb_cyc_o !== 1'b0) begin
                    n_err++; $display("FAIL reset_async_cyc: got %b want 0", wbif.wb_cyc_o);
                end
            end
        join
        enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (wbif.wb_cyc_o !== 1'b0) begin n_err++; $display("FAIL reset_cyc: got %b want 0", wbif.wb_cyc_o); end
        n_cmp++; if (wbif.wb_we_o !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b want 0", wbif.wb_we_o); end
        n_cmp++; if (wbif.wb_adr_o !== 19'd0) begin n_err++; $display("FAIL reset_adr: got %0d want 0", wbif.wb_adr_o); end
        n_cmp++; if (wbif.wb_dat_o !== 8'd0) begin n_err++; $display("FAIL reset_dat: got %02h want 00", wbif.wb_dat_o); end
        n_cmp++; if (addr_o !== 19'd44) begin n_err++; $display("FAIL reset_addr: got %0d want 44", addr_o); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", ovr); end
        n_cmp++; if (got.size() != 0) begin n_err++; $display("FAIL reset_no_write: got %0d writes want 0", got.size()); end
    endtask

    task automatic run_frames(input string name, input int nb, input int end_a);
        end_addr = AW'(end_a);
        enable = 1'b1;
        repeat (4) @(negedge clk);
        send_stream(nb);
        model_run(tx_l.size(), end_a, -1);
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            n_err++; $display("FAIL %s_count: got %0d writes want %0d", name, got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL %s_byte%0d: got adr=%0d dat=%02h want adr=%0d dat=%02h",
                         name, i, got[i][26:8], got[i][7:0], exp_q[i][26:8], exp_q[i][7:0]);
            end
        end
        n_cmp++;
        if (addr_o !== AW'(exp_addr)) begin
            n_err++; $display("FAIL %s_addr: got %0d want %0d", name, addr_o, exp_addr);
        end
        n_cmp++;
        if (full !== exp_full) begin
            n_err++; $display("FAIL %s_full: got %b want %b", name, full, exp_full);
        end
    endtask

    task automatic test_single();
        do_reset();
        tx_l.push_back(16'hA55A); tx_r.push_back(16'h1234);
        run_frames("single", 32, 'h7FFFF);
        n_cmp++;
        if (busy !== 1'b1) begin n_err++; $display("FAIL single_busy: got %b want 1", busy); end
    endtask

    task automatic test_exact16();
        do_reset();
        tx_l.push_back(16'h8001); tx_r.push_back(16'h7FFE);
        for (int f = 0; f < 2; f++) begin
            tx_l.push_back(16'($urandom)); tx_r.push_back(16'($urandom));
        end
        run_frames("exact16", 16, 'h7FFFF);
    endtask

    task automatic test_random();
        int nbs[4] = '{16, 18, 24, 32};
        for (int it = 0; it < 2; it++) begin
            do_reset();
            for (int f = 0; f < 4; f++) begin
                tx_l.push_back(16'($urandom)); tx_r.push_back(16'($urandom));
            end
            run_frames("random", nbs[$urandom_range(3)], 1000);
        end
    endtask

    task automatic test_full();
        do_reset();
        for (int f = 0; f < 3; f++) begin
            tx_l.push_back(16'($urandom)); tx_r.push_back(16'($urandom));
        end
        run_frames("full", 32, 51);
        n_cmp++;
        if (busy !== 1'b0) begin n_err++; $display("FAIL full_busy: got %b want 0", busy); end
    endtask

    task automatic test_overrun();
        bit seen;
        do_reset();
        ack_en = 1'b0;
        end_addr = '1;
        for (int f = 0; f < 3; f++) begin
            tx_l.push_back(16'($urandom)); tx_r.push_back(16'($urandom));
        end
        enable = 1'b1;
        repeat (4) @(negedge clk);
        fork
            send_stream(32);
            begin
                seen = 1'b0;
                for (int t = 0; t < 3000 && !seen; t++) begin
                    @(negedge clk);
                    if (ovr === 1'b1) seen = 1'b1;
                end
                n_cmp++;
                if (!seen) begin
                    n_err++; $display("FAIL overrun_flag: got overrun never set, want set within 3000 cycles");
                end
                ack_en = 1'b1;
            end
        join
        model_run(3, 'h7FFFF, 1);
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            n_err++; $display("FAIL overrun_count: got %0d writes want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL overrun_byte%0d: got adr=%0d dat=%02h want adr=%0d dat=%02h",
                         i, got[i][26:8], got[i][7:0], exp_q[i][26:8], exp_q[i][7:0]);
            end
        end
        n_cmp++;
        if (ovr !== 1'b1) begin n_err++; $display("FAIL overrun_sticky: got %b want 1", ovr); end
        enable = 1'b0;
        repeat (2) @(negedge clk);
        enable = 1'b1;
        repeat (2) @(negedge clk);
        n_cmp++; if (ovr !== 1'b0) begin n_err++; $display("FAIL overrun_rearm_clear: got %b want 0", ovr); end
        n_cmp++; if (addr_o !== 19'd44) begin n_err++; $display("FAIL overrun_rearm_addr: got %0d want 44", addr_o); end
    endtask

    task automatic test_stop();
        bit seen;
        do_reset();
        end_addr = '1;
        for (int f = 0; f < 2; f++) begin
            tx_l.push_back(16'($urandom)); tx_r.push_back(16'($urandom));
        end
        enable = 1'b1;
        repeat (4) @(negedge clk);
        fork
            send_stream(32);
            begin
                seen = 1'b0;
                for (int t = 0; t < 3000 && !seen; t++) begin
                    @(negedge clk);
                    if (got.size() >= 2) seen = 1'b1;
                end
                n_cmp++;
                if (!seen) begin
                    n_err++; $display("FAIL stop_byte1: got %0d writes, want 2 within 3000 cycles", got.size());
                end
                enable = 1'b0;
            end
        join
        model_run(1, 'h7FFFF, -1);
        n_cmp++;
        if (got.size() != exp_q.size()) begin
            n_err++; $display("FAIL stop_count: got %0d writes want %0d", got.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
            n_cmp++;
            if (got[i] !== exp_q[i]) begin
                n_err++;
                $display("FAIL stop_byte%0d: got adr=%0d dat=%02h want adr=%0d dat=%02h",
                         i, got[i][26:8], got[i][7:0], exp_q[i][26:8], exp_q[i][7:0]);
            end
        end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL stop_busy: got %b want 0", busy); end
        n_cmp++; if (addr_o !== AW'(exp_addr)) begin n_err++; $display("FAIL stop_addr: got %0d want %0d", addr_o, exp_addr); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_exact16();
        test_random();
        test_full();
        test_overrun();
        test_stop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/i2s_rec.md
# i2s_rec

I2S slave receiver and SRAM recorder for the audio shield capture path, the counterpart of the DAC playback serializer. Deserializes stereo samples from the ADC (external Bclk/Wclk, data MSB-first), packs each stereo frame into four little-endian bytes and writes them to SRAM through the shared Wishbone port. Byte order in memory matches the playback reader's order, so recorded buffers replay unchanged: left low, left high, right low, right high, starting after the 44-byte WAV header.

## Interface
- SAMPLE_W, 16, bits captured per channel (MSB-first; extra Bclk bits ignored)
- ADDR_W, 19, SRAM byte address width
- START_ADDR, 44, first byte address written when recording starts

- clk_i  in  1  system clock; all logic on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- enable_i  in  1  level; 1 = record, 0 = stop after current frame
- bclk_i  in  1  I2S bit clock from ADC, asynchronous to clk_i
- wclk_i  in  1  I2S word select (0 = left, 1 = right), asynchronous
- din_i  in  1  I2S serial data from ADC
- end_addr_i  in  ADDR_W  last byte address usable for recording
- wb_cyc_o  out  1  Wishbone cycle/strobe
- wb_we_o  out  1  Wishbone write enable
- wb_adr_o  out  ADDR_W  byte address
- wb_dat_o  out  8  write data
- wb_ack_i  in  1  Wishbone acknowledge
- addr_o  out  ADDR_W  next address to be written (equals final fill address after stop)
- busy_o  out  1  1 while recording is armed or a frame write is in progress
- full_o  out  1  sticky: end_addr_i reached
- overrun_o  out  1  sticky: frame dropped because the previous write was unfinished

## Operation
- Sync: bclk_i, wclk_i, din_i each pass through a 2-flop synchronizer. A registered copy of synced Bclk gives a one-cycle rising-edge pulse `bedge`.
- Deserializer (every bedge): sample ws = synced wclk and d = synced din; ws_d holds ws from the previous bedge.
  - ws != ws_d: if cnt < SAMPLE_W, shift d in as the LSB. Then latch the shift register into the channel selected by ws_d (0 → left, 1 → right). Set cnt = 0.
  - ws == ws_d, cnt < SAMPLE_W: shift d in (MSB first), cnt++. Bits beyond SAMPLE_W are ignored. cnt saturates.
  - A word is valid only if it followed a ws change seen while armed. The first partial word after arming is discarded.
- Arming: on a rising edge of enable_i (registered), set addr = START_ADDR and clear full_o and overrun_o. The first frame recorded is the first complete left word followed by its right word.
- Frame commit: a right-word latch while armed, with a valid left word pending, raises `frame_rdy` (one cycle).
- Write FSM:
  - IDLE: on frame_rdy, if addr + 3 <= end_addr_i, go to REQ with idx = 0. Otherwise set full_o, disarm, stay in IDLE.
  - REQ: wb_cyc_o = wb_we_o = 1, wb_adr_o = addr, wb_dat_o = byte[idx] (0 = L[7:0], 1 = L[15:8], 2 = R[7:0], 3 = R[15:8]). Hold until wb_ack_i = 1, then go to GAP.
  - GAP: wb_cyc_o = 0, addr++. If idx == 3, go to IDLE; else idx++ and go to REQ.
- Frame data is copied into a 32-bit holding register at frame_rdy, so the deserializer may run on during the write.
- frame_rdy while the FSM is not IDLE: the frame is dropped, overrun_o = 1, and the write in progress continues.
- enable_i falling: disarm immediately. A frame write in progress completes all 4 bytes, then the FSM goes to IDLE. addr_o holds its value.
- Arithmetic: addr is ADDR_W bits. The full check is done in ADDR_W+1 bits so it cannot wrap. addr never passes end_addr_i + 1.

## Timing
- Reset values: wb_cyc_o = 0, wb_we_o = 0, wb_adr_o = 0, wb_dat_o = 0, addr_o = START_ADDR, busy_o = 0, full_o = 0, overrun_o = 0. Synchronizers, shift register, cnt and FSM also clear.
- rst_i asserted mid-cycle: wb_cyc_o drops asynchronously. The partial frame is lost.
- Input constraint: Bclk frequency must not exceed clk_i/4 (each high and low phase at least 2 clk_i cycles).
- bedge lags the physical Bclk rise by 3 clk_i cycles. Data and word select share the same latency.
- frame_rdy follows the bedge of the right→left ws change by 1 cycle. wb_cyc_o rises on the next cycle.
- Per byte: 1 cycle minimum in REQ plus ack wait, then 1 GAP cycle. With single-cycle ack, a frame takes 8 clk_i cycles from the first cyc to IDLE.
- wb_adr_o and wb_dat_o are stable for the whole time wb_cyc_o is high.

## Test plan
- Reset: assert rst_i mid-write → wb_cyc_o = 0 within the same cycle; after release, all outputs hold their reset values.
- Single frame: clk 12 MHz, 32 Bclk per channel, L = 0xA55A, R = 0x1234, enable after header → writes 0x5A@44, 0xA5@45, 0x34@46, 0x12@47; addr_o = 48.
- Exact 16-bit frames: 16 Bclk per channel, where the LSB falls on the ws-change edge; L = 0x8001, R = 0x7FFE → bytes 01 80 FE 7F.
- Full: end_addr_i = 51, three frames sent → two frames written (44..51), full_o = 1, no third cycle, addr_o = 52.
- Overrun: hold wb_ack_i low for a whole frame period → overrun_o = 1, the next frame is dropped, the held write completes once ack is given, and flags clear on re-enable.
- Stop mid-write: deassert enable_i after byte 1 is acked → bytes 2 and 3 are still written, then no more cycles; busy_o = 0 and addr_o = 48.
